id_hazard_ctrl: RTL and testbench
=================================

# id_hazard_ctrl

Pipeline hazard and stall controller for the five-stage MIPS core. It compares the decode-stage source registers against a load in EX and inserts a one-cycle bubble on a load-use hazard. It flushes IF/ID and ID/EX on a taken branch, and freezes the whole pipeline while data memory is busy. It drives the `hazard_detected` input of the decode Control unit and the write enables of PC and IF/ID.

## Interface
Parameters:
- REG_ADDR_W, 5, register-number width
- MAX_WAIT, 64, MEM_WAIT cycle limit before `wait_err` sets (≥2)
- PERF_W, 16, perf counter width

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- id_valid  in  1  ID holds a real instruction
- id_rs  in  REG_ADDR_W  IF/ID inst[25:21]
- id_rt  in  REG_ADDR_W  IF/ID inst[20:16]
- id_uses_rt  in  1  ID instruction reads rt (R-type, beq, sw)
- ex_memread  in  1  ID/EX MemRead
- ex_rt  in  REG_ADDR_W  ID/EX load destination
- ex_branch_taken  in  1  branch resolved taken in EX
- mem_busy  in  1  data memory not ready this cycle
- pc_write  out  1  PC load enable
- ifid_write  out  1  IF/ID load enable
- id_bubble  out  1  zero control into ID/EX (to Control `hazard_detected`)
- if_flush  out  1  clear IF/ID to NOP
- pipe_hold  out  1  hold ID/EX, EX/MEM, MEM/WB
- wait_err  out  1  sticky watchdog error
- perf_stall  out  PERF_W  load-use stall cycles
- perf_flush  out  PERF_W  flushes applied

## Operation
- State register: RUN, MEM_WAIT. Also `flush_pend` flag, `wait_cnt` (clog2(MAX_WAIT)+1 bits).
- Load-use hazard (lu) is asserted when all of these hold:
  - id_valid
  - ex_memread
  - ex_rt≠0
  - ex_rt==id_rs, or (id_uses_rt and ex_rt==id_rt)
- Output priority, evaluated every cycle (Mealy):
  1. mem_busy=1, any state:
     - pipe_hold=1; pc_write=0; ifid_write=0; id_bubble=0; if_flush=0
     - next state MEM_WAIT
     - if ex_branch_taken=1, set flush_pend
  2. flush = ex_branch_taken or (state==MEM_WAIT and flush_pend):
     - pc_write=1; ifid_write=1; if_flush=1; id_bubble=1
     - clear flush_pend; next state RUN
     - a flush overrides lu, because the dependent instruction is squashed
  3. lu:
     - pc_write=0; ifid_write=0; id_bubble=1; if_flush=0
  4. otherwise:
     - pc_write=1; ifid_write=1; all others 0
- Leaving MEM_WAIT: on the first cycle with mem_busy=0, the next state is RUN.
- Watchdog:
  - wait_cnt clears on entry to MEM_WAIT and increments each MEM_WAIT cycle, saturating at MAX_WAIT.
  - When wait_cnt reaches MAX_WAIT, wait_err sets and stays set until reset.
  - wait_err never forces the state machine out of MEM_WAIT.
- Register 0 never causes a hazard.

## Timing
- Reset, while rst=0:
  - state RUN; flush_pend=0; wait_cnt=0; wait_err=0; perf counters 0
  - all outputs 0, including pc_write and ifid_write
- After release: outputs follow the priority rules from the first clock.
- Latency:
  - lu and flush act combinationally in the same cycle their inputs appear.
  - Load-use stall lasts exactly one cycle; the bubble removes ex_memread on the next cycle.
- Deferred flush: a branch taken during mem_busy is applied exactly one cycle after mem_busy falls. The applying cycle is the first non-busy cycle and no cycle is lost.
- Simultaneous branch and lu: flush only; perf_stall does not increment.
- Reset asserted mid-MEM_WAIT: asynchronous return to RUN and flush_pend is discarded.
- Perf counters wrap modulo 2^PERF_W.

## Configuration
- HAZ_PERF_EN defined:
  - perf_stall increments on each cycle with priority-3 lu.
  - perf_flush increments on each cycle with if_flush=1.
- HAZ_PERF_EN undefined:
  - counters are not synthesized and both ports are tied to 0.
  - ports remain in the interface.

## Structure
- Shared package `mips_pkg`:
  - state enum `haz_state_t` (RUN, MEM_WAIT)
  - REG_ADDR_W default
  - ZERO_REG constant
- One sub-module: `haz_perf_cnt`, a saturation-free wrapping counter with enable. It is instantiated twice, inside the `ifdef`.

## Test plan
- Load-use:
  - Stimulus: ex_memread=1, ex_rt=5, id_rs=5, id_valid=1, then ex_memread=0.
  - Response: one cycle of pc_write=0, ifid_write=0, id_bubble=1, then normal; perf_stall=1.
- rt gating:
  - Stimulus: ex_rt=7=id_rt with id_uses_rt=0, then 1.
  - Response: no stall, then stall.
- Zero register:
  - Stimulus: ex_memread=1, ex_rt=0=id_rs.
  - Response: no stall.
- Branch over lu:
  - Stimulus: ex_branch_taken=1 together with a load-use match.
  - Response: if_flush=1, id_bubble=1, pc_write=1; perf_flush=1, perf_stall=0.
- Deferred flush:
  - Stimulus: mem_busy=1 for 3 cycles with ex_branch_taken pulsed in cycle 2, then mem_busy=0.
  - Response: pipe_hold=1 for 3 cycles; if_flush=1 in the first free cycle only.
- Watchdog and reset:
  - Stimulus: mem_busy held 64 cycles, then rst=0.
  - Response: wait_err rises once wait_cnt reaches 64; rst=0 clears it and forces all outputs to 0 asynchronously.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS core control blocks.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mips_pkg;

  // Default register-number width (32 architectural registers)
  localparam int REG_ADDR_W_DFLT = 5;

  // $zero is hard-wired, so it can never carry a load-use dependency
  localparam int ZERO_REG = 0;

  // Hazard controller state: normal flow, or frozen behind a busy data memory
  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } haz_state_t;

endpackage

// File: rtl/haz_perf_cnt.sv
// Free-running wrapping event counter with enable.
// Latency: count reflects an enabled cycle after the following rising edge.
// Backpressure: none; wraps modulo 2^W.
module haz_perf_cnt #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  output logic [W-1:0] count
);

  // Count enabled cycles; natural overflow gives the modulo wrap
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (en) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/id_hazard_ctrl.sv
// Load-use stall, branch flush and memory-busy freeze controller for the 5-stage pipe.
// Latency: stall/flush/hold act combinationally in the cycle their inputs appear.
// Backpressure: mem_busy freezes everything; a branch seen while frozen is replayed on the first free cycle.
// Optional perf counters are built only when HAZ_PERF_EN is defined; otherwise the ports read 0.
module id_hazard_ctrl
  import mips_pkg::*;
#(
  parameter int REG_ADDR_W = REG_ADDR_W_DFLT,
  parameter int MAX_WAIT   = 64,
  parameter int PERF_W     = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic                  id_uses_rt,
  input  logic                  ex_memread,
  input  logic [REG_ADDR_W-1:0] ex_rt,
  input  logic                  ex_branch_taken,
  input  logic                  mem_busy,
  output logic                  pc_write,
  output logic                  ifid_write,
  output logic                  id_bubble,
  output logic                  if_flush,
  output logic                  pipe_hold,
  output logic                  wait_err,
  output logic [PERF_W-1:0]     perf_stall,
  output logic [PERF_W-1:0]     perf_flush
);

  // One extra bit so the counter can hold MAX_WAIT itself
  localparam int             CNT_W   = $clog2(MAX_WAIT) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_WAIT);

  haz_state_t       state, state_nxt;
  logic             flush_pend, flush_pend_nxt;
  logic [CNT_W-1:0] wait_cnt, wait_cnt_nxt;
  logic             lu;
  logic             flush;

  // Load-use: a load in EX writes a register the ID instruction reads
  always_comb begin
    lu = id_valid && ex_memread && (ex_rt != REG_ADDR_W'(ZERO_REG)) &&
         ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
  end

  // Priority decode of pipeline controls; outputs held low while in reset
  always_comb begin
    pc_write       = 1'b0;
    ifid_write     = 1'b0;
    id_bubble      = 1'b0;
    if_flush       = 1'b0;
    pipe_hold      = 1'b0;
    state_nxt      = state;
    flush_pend_nxt = flush_pend;
    flush          = ex_branch_taken || ((state == MEM_WAIT) && flush_pend);
    if (rst) begin
      if (mem_busy) begin
        // Freeze; remember a taken branch so it is not lost while frozen
        pipe_hold = 1'b1;
        state_nxt = MEM_WAIT;
        if (ex_branch_taken) begin
          flush_pend_nxt = 1'b1;
        end
      end else if (flush) begin
        // Flush beats load-use: the dependent instruction is squashed anyway
        pc_write       = 1'b1;
        ifid_write     = 1'b1;
        if_flush       = 1'b1;
        id_bubble      = 1'b1;
        flush_pend_nxt = 1'b0;
        state_nxt      = RUN;
      end else if (lu) begin
        id_bubble = 1'b1;
        state_nxt = RUN;
      end else begin
        pc_write   = 1'b1;
        ifid_write = 1'b1;
        state_nxt  = RUN;
      end
    end
  end

  // Watchdog count: cleared on entry to MEM_WAIT, saturating while there
  always_comb begin
    wait_cnt_nxt = wait_cnt;
    if ((state == RUN) && mem_busy) begin
      wait_cnt_nxt = '0;
    end else if ((state == MEM_WAIT) && (wait_cnt != CNT_MAX)) begin
      wait_cnt_nxt = wait_cnt + CNT_W'(1);
    end
  end

  // State, pending flush, watchdog and sticky error registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= RUN;
      flush_pend <= 1'b0;
      wait_cnt   <= '0;
      wait_err   <= 1'b0;
    end else begin
      state      <= state_nxt;
      flush_pend <= flush_pend_nxt;
      wait_cnt   <= wait_cnt_nxt;
      if (wait_cnt_nxt == CNT_MAX) begin
        wait_err <= 1'b1;
      end
    end
  end

`ifdef HAZ_PERF_EN
  // A bubble without a flush is exactly a priority-3 load-use stall
  logic stall_evt;
  assign stall_evt = id_bubble & ~if_flush;

  haz_perf_cnt #(.W(PERF_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .en    (stall_evt),
    .count (perf_stall)
  );

  haz_perf_cnt #(.W(PERF_W)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .en    (if_flush),
    .count (perf_flush)
  );
`else
  assign perf_stall = '0;
  assign perf_flush = '0;
`endif

endmodule

// File: tb/tb_id_hazard_ctrl.sv
// Self-checking bench for id_hazard_ctrl: directed scenarios plus random traffic.
// Expected behaviour comes from a cycle-level reference model of the pipeline rules.
// Perf expectations follow HAZ_PERF_EN the same way the design does.
module tb_id_hazard_ctrl;

  localparam int AW       = 5;
  localparam int MAX_WAIT = 64;
  localparam int PERF_W   = 16;

  logic          clk;
  logic          rst;
  logic          id_valid;
  logic [AW-1:0] id_rs;
  logic [AW-1:0] id_rt;
  logic          id_uses_rt;
  logic          ex_memread;
  logic [AW-1:0] ex_rt;
  logic          ex_branch_taken;
  logic          mem_busy;
  logic          pc_write;
  logic          ifid_write;
  logic          id_bubble;
  logic          if_flush;
  logic          pipe_hold;
  logic          wait_err;
  logic [PERF_W-1:0] perf_stall;
  logic [PERF_W-1:0] perf_flush;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  bit m_frozen_last;   // previous clocked cycle had memory busy
  bit m_pend;          // branch seen while frozen, not yet applied
  int m_wait_cycles;   // cycles spent waiting on memory (saturating)
  bit m_err;
  int m_stalls;
  int m_flushes;

  id_hazard_ctrl #(
    .REG_ADDR_W (AW),
    .MAX_WAIT   (MAX_WAIT),
    .PERF_W     (PERF_W)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .id_valid        (id_valid),
    .id_rs           (id_rs),
    .id_rt           (id_rt),
    .id_uses_rt      (id_uses_rt),
    .ex_memread      (ex_memread),
    .ex_rt           (ex_rt),
    .ex_branch_taken (ex_branch_taken),
    .mem_busy        (mem_busy),
    .pc_write        (pc_write),
    .ifid_write      (ifid_write),
    .id_bubble       (id_bubble),
    .if_flush        (if_flush),
    .pipe_hold       (pipe_hold),
    .wait_err        (wait_err),
    .perf_stall      (perf_stall),
    .perf_flush      (perf_flush)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_frozen_last = 1'b0;
    m_pend        = 1'b0;
    m_wait_cycles = 0;
    m_err         = 1'b0;
    m_stalls      = 0;
    m_flushes     = 0;
  endtask

  // Compare all outputs against the model, then advance the model over the coming edge
  task automatic check_and_advance();
    bit                dep;
    bit                squash;
    logic [4:0]        exp_ctl;
    logic [PERF_W-1:0] exp_ps;
    logic [PERF_W-1:0] exp_pf;
    dep    = id_valid && ex_memread && (ex_rt != 0) &&
             ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
    squash = !mem_busy && (ex_branch_taken || (m_frozen_last && m_pend));
    // {pc_write, ifid_write, id_bubble, if_flush, pipe_hold}
    if (mem_busy)    exp_ctl = 5'b00001;
    else if (squash) exp_ctl = 5'b11110;
    else if (dep)    exp_ctl = 5'b00100;
    else             exp_ctl = 5'b11000;
`ifdef HAZ_PERF_EN
    exp_ps = PERF_W'(m_stalls);
    exp_pf = PERF_W'(m_flushes);
`else
    exp_ps = '0;
    exp_pf = '0;
`endif
    check_eq("ctl", {27'd0, pc_write, ifid_write, id_bubble, if_flush, pipe_hold}, {27'd0, exp_ctl});
    check_eq("wait_err", {31'd0, wait_err}, {31'd0, m_err});
    check_eq("perf_stall", {16'd0, perf_stall}, {16'd0, exp_ps});
    check_eq("perf_flush", {16'd0, perf_flush}, {16'd0, exp_pf});
    // Watchdog: every cycle spent waiting (including the release cycle) counts
    if (m_frozen_last) begin
      if (m_wait_cycles < MAX_WAIT) m_wait_cycles++;
      if (m_wait_cycles == MAX_WAIT) m_err = 1'b1;
    end else if (mem_busy) begin
      m_wait_cycles = 0;
    end
    if (mem_busy) begin
      if (ex_branch_taken) m_pend = 1'b1;
    end else if (squash) begin
      m_pend = 1'b0;
      m_flushes++;
    end else if (dep) begin
      m_stalls++;
    end
    m_frozen_last = mem_busy;
  endtask

  // One clock cycle: drive on the falling edge, check 1ns later
  task automatic cyc(input bit v, input bit mr, input logic [AW-1:0] ert,
                     input logic [AW-1:0] rs, input logic [AW-1:0] rt,
                     input bit urt, input bit br, input bit busy);
    @(negedge clk);
    id_valid        = v;
    ex_memread      = mr;
    ex_rt           = ert;
    id_rs           = rs;
    id_rt           = rt;
    id_uses_rt      = urt;
    ex_branch_taken = br;
    mem_busy        = busy;
    #1;
    check_and_advance();
  endtask

  initial begin
    rst = 1'b0;
    id_valid = 1'b1; ex_memread = 1'b1; ex_rt = 5'd5; id_rs = 5'd5; id_rt = 5'd0;
    id_uses_rt = 1'b0; ex_branch_taken = 1'b0; mem_busy = 1'b0;
    model_reset();

    // Reset state: every output low even with a hazard on the inputs
    #1;
    check_eq("rst_ctl", {27'd0, pc_write, ifid_write, id_bubble, if_flush, pipe_hold}, 32'd0);
    check_eq("rst_err", {31'd0, wait_err}, 32'd0);
    check_eq("rst_perf", {perf_stall, perf_flush}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // Load-use on rs: one stall cycle, then normal once the bubble clears memread
    cyc(1, 1, 5, 5, 0, 0, 0, 0);
    check_eq("lu_stall", {29'd0, pc_write, ifid_write, id_bubble}, 32'b001);
    cyc(1, 0, 5, 5, 0, 0, 0, 0);
    check_eq("lu_after", {29'd0, pc_write, ifid_write, id_bubble}, 32'b110);

    // rt only matters when the instruction reads rt
    cyc(1, 1, 7, 3, 7, 0, 0, 0);
    check_eq("rt_gate_off", {31'd0, id_bubble}, 32'd0);
    cyc(1, 1, 7, 3, 7, 1, 0, 0);
    check_eq("rt_gate_on", {31'd0, id_bubble}, 32'd1);

    // $zero never stalls
    cyc(1, 1, 0, 0, 0, 1, 0, 0);
    check_eq("zero_reg", {31'd0, pc_write}, 32'd1);

    // Branch and load-use together: flush wins
    cyc(1, 1, 5, 5, 0, 0, 1, 0);
    check_eq("br_over_lu", {28'd0, pc_write, id_bubble, if_flush, pipe_hold}, 32'b1110);

    // Deferred flush: branch during busy applied on the first free cycle only
    cyc(1, 0, 0, 1, 2, 0, 0, 1);
    cyc(1, 0, 0, 1, 2, 0, 1, 1);
    check_eq("def_hold", {30'd0, pipe_hold, if_flush}, 32'b10);
    cyc(1, 0, 0, 1, 2, 0, 0, 1);
    cyc(1, 0, 0, 1, 2, 0, 0, 0);
    check_eq("def_flush", {30'd0, if_flush, pc_write}, 32'b11);
    cyc(1, 0, 0, 1, 2, 0, 0, 0);
    check_eq("def_once", {31'd0, if_flush}, 32'd0);

    // Watchdog: 64 busy cycles plus the release cycle reach the limit
    for (int i = 0; i < MAX_WAIT; i++) cyc(1, 0, 0, 1, 2, 0, 0, 1);
    check_eq("wd_pre", {31'd0, wait_err}, 32'd0);
    cyc(1, 0, 0, 1, 2, 0, 0, 0);
    cyc(1, 0, 0, 1, 2, 0, 0, 0);
    check_eq("wd_post", {31'd0, wait_err}, 32'd1);

    // Reset mid-wait with a pending branch: async clear, pending flush dropped
    cyc(1, 0, 0, 1, 2, 0, 1, 1);
    cyc(1, 0, 0, 1, 2, 0, 0, 1);
    #2;
    rst = 1'b0;
    #1;
    check_eq("arst_ctl", {27'd0, pc_write, ifid_write, id_bubble, if_flush, pipe_hold}, 32'd0);
    check_eq("arst_err", {31'd0, wait_err}, 32'd0);
    check_eq("arst_perf", {perf_stall, perf_flush}, 32'd0);
    model_reset();
    @(negedge clk);
    mem_busy = 1'b0;
    ex_branch_taken = 1'b0;
    rst = 1'b1;
    #1;
    check_eq("arst_nopend", {31'd0, if_flush}, 32'd0);
    check_and_advance();

    // Random traffic with narrow register range to provoke matches
    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom % 8) != 0, ($urandom % 2) == 1,
          AW'($urandom_range(0, 3)), AW'($urandom_range(0, 3)), AW'($urandom_range(0, 3)),
          ($urandom % 2) == 1, ($urandom % 8) == 0, ($urandom % 4) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
